fpu_op_issuer: RTL and testbench

FPU_OP_ISSUER -- requirements
Module: fpu_op_issuer

---
 rtl/fpu_op_issuer_pkg.sv | 29 ++
 rtl/fpu_op_issuer_if.sv | 55 +++++
 rtl/fpu_timeout_counter.sv | 29 ++
 rtl/fpu_op_issuer.sv | 158 +++++++++++++++
 tb/tb_fpu_op_issuer.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fpu_op_issuer_pkg.sv
// Shared FPU definitions: opcode encoding, issuer FSM states and opcode helpers.
package fpu_op_issuer_pkg;

  typedef enum logic [1:0] {
    SDIV  = 2'b00,
    SSQRT = 2'b01,
    DDIV  = 2'b10,
    DSQRT = 2'b11
  } fpu_op_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SEND   = 3'd2,
    WAIT_Z = 3'd3,
    ACK_Z  = 3'd4,
    RESP   = 3'd5
  } issuer_state_e;

  // Division needs a second operand; square root does not.
  function automatic logic op_needs_b(input fpu_op_e op);
    return (op == SDIV) || (op == DDIV);
  endfunction

  function automatic logic op_is_double(input fpu_op_e op);
    return (op == DDIV) || (op == DSQRT);
  endfunction

endpackage

// File: rtl/fpu_op_issuer_if.sv
// Bundle between a command/response client, the issuer and the FPU unit.
// slave is the issuer's view; master is the environment (client plus FPU unit).
interface fpu_op_issuer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [63:0] cmd_a;
  logic [63:0] cmd_b;

  logic [1:0]  process;
  logic [31:0] input_as;
  logic [31:0] input_bs;
  logic [63:0] input_ad;
  logic [63:0] input_bd;
  logic        input_a_stb;
  logic        input_b_stb;
  logic        input_a_ack;
  logic        input_b_ack;

  logic [31:0] output_zs;
  logic [63:0] output_zd;
  logic        output_z_stb;
  logic        output_z_ack;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_op;
  logic        rsp_timeout;

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  input_a_ack, input_b_ack,
    input  output_zs, output_zd, output_z_stb,
    input  rsp_ready,
    output cmd_ready,
    output process, input_as, input_bs, input_ad, input_bd,
    output input_a_stb, input_b_stb,
    output output_z_ack,
    output rsp_valid, rsp_data, rsp_op, rsp_timeout
  );

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output input_a_ack, input_b_ack,
    output output_zs, output_zd, output_z_stb,
    output rsp_ready,
    input  cmd_ready,
    input  process, input_as, input_bs, input_ad, input_bd,
    input  input_a_stb, input_b_stb,
    input  output_z_ack,
    input  rsp_valid, rsp_data, rsp_op, rsp_timeout
  );

endinterface

// File: rtl/fpu_timeout_counter.sv
// Cycle counter that flags the last allowed cycle of an operation window.
module fpu_timeout_counter #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // High during the LIMIT-th enabled cycle so the owner leaves after exactly LIMIT cycles.
  assign expired = enable && (count_reg == W'(LIMIT - 1));

endmodule

// File: rtl/fpu_op_issuer.sv
// Issues one div/sqrt operation to a strobe/ack FPU unit and returns its result,
// aborting with a timeout flag if the unit stalls.
module fpu_op_issuer
  import fpu_op_issuer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  fpu_op_issuer_if.slave bus
);

  issuer_state_e state_reg, state_next;

  fpu_op_e     op_reg;
  logic [63:0] a_reg;
  logic [63:0] b_reg;
  logic        a_done_reg;
  logic        b_done_reg;
  logic [63:0] rsp_data_reg;
  logic        rsp_timeout_reg;

  logic cmd_ready;
  logic a_stb;
  logic b_stb;
  logic z_ack;
  logic rsp_valid;
  logic cnt_clear;
  logic cnt_enable;
  logic cnt_expired;
  logic capture_z;
  logic timeout_hit;
  logic all_acked;
  logic cmd_accept;

  fpu_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .expired (cnt_expired)
  );

  // Acks arriving in the current cycle count alongside ones already recorded.
  assign all_acked = (a_done_reg || bus.input_a_ack) &&
                     (!op_needs_b(op_reg) || b_done_reg || bus.input_b_ack);
  assign cmd_accept = cmd_ready && bus.cmd_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cmd_ready   = 1'b0;
    a_stb       = 1'b0;
    b_stb       = 1'b0;
    z_ack       = 1'b0;
    rsp_valid   = 1'b0;
    cnt_clear   = 1'b0;
    cnt_enable  = 1'b0;
    capture_z   = 1'b0;
    timeout_hit = 1'b0;
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_valid) state_next = SETUP;
      end
      SETUP: begin
        cnt_clear  = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        cnt_enable = 1'b1;
        a_stb      = !a_done_reg;
        b_stb      = op_needs_b(op_reg) && !b_done_reg;
        if (cnt_expired) begin
          timeout_hit = 1'b1;
          state_next  = RESP;
        end else if (all_acked) begin
          state_next = WAIT_Z;
        end
      end
      WAIT_Z: begin
        cnt_enable = 1'b1;
        if (cnt_expired) begin
          timeout_hit = 1'b1;
          state_next  = RESP;
        end else if (bus.output_z_stb) begin
          capture_z  = 1'b1;
          state_next = ACK_Z;
        end
      end
      ACK_Z: begin
        z_ack = 1'b1;
        if (!bus.output_z_stb) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg          <= SDIV;
      a_reg           <= '0;
      b_reg           <= '0;
      a_done_reg      <= 1'b0;
      b_done_reg      <= 1'b0;
      rsp_data_reg    <= '0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      if (cmd_accept) begin
        op_reg          <= fpu_op_e'(bus.cmd_op);
        a_reg           <= bus.cmd_a;
        b_reg           <= bus.cmd_b;
        a_done_reg      <= 1'b0;
        b_done_reg      <= 1'b0;
        rsp_timeout_reg <= 1'b0;
      end
      if (state_reg == SEND) begin
        a_done_reg <= a_done_reg || bus.input_a_ack;
        b_done_reg <= b_done_reg || bus.input_b_ack;
      end
      if (capture_z) begin
        rsp_data_reg <= op_is_double(op_reg) ? bus.output_zd : {32'h0, bus.output_zs};
      end
      if (timeout_hit) begin
        rsp_data_reg    <= '0;
        rsp_timeout_reg <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready    = cmd_ready;
  assign bus.process      = op_reg;
  assign bus.input_as     = a_reg[31:0];
  assign bus.input_bs     = b_reg[31:0];
  assign bus.input_ad     = a_reg;
  assign bus.input_bd     = b_reg;
  assign bus.input_a_stb  = a_stb;
  assign bus.input_b_stb  = b_stb;
  assign bus.output_z_ack = z_ack;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.rsp_data     = rsp_data_reg;
  assign bus.rsp_op       = op_reg;
  assign bus.rsp_timeout  = rsp_timeout_reg;

endmodule

// File: tb/tb_fpu_op_issuer.sv
// Directed and randomized operations against a cycle-level expectation derived from ack/z delays.
module tb_fpu_op_issuer;

  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_op_issuer_if bus ();

  fpu_op_issuer #(
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int txn    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 64'd1);
    chk({tag, "_a_stb"}, bus.input_a_stb, 64'd0);
    chk({tag, "_b_stb"}, bus.input_b_stb, 64'd0);
    chk({tag, "_z_ack"}, bus.output_z_ack, 64'd0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 64'd0);
    chk({tag, "_rsp_timeout"}, bus.rsp_timeout, 64'd0);
    chk({tag, "_rsp_data"}, bus.rsp_data, 64'd0);
    chk({tag, "_process"}, bus.process, 64'd0);
    chk({tag, "_input_ad"}, bus.input_ad, 64'd0);
    chk({tag, "_input_bd"}, bus.input_bd, 64'd0);
  endtask

  // One full operation. The FPU model acks a after a_dly SEND cycles (b after b_dly),
  // raises z z_dly cycles into WAIT_Z (never if z_never), keeps z high z_hold cycles
  // past seeing the ack, and the client stalls rsp_ready for hold cycles.
  task automatic do_op(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [31:0] zs, input logic [63:0] zd,
                       input int a_dly, input int b_dly, input int z_dly, input int z_hold,
                       input int hold, input bit z_never, input int rst_at);
    bit          need_b;
    bit          to;
    int          n_send, wait_len, z_start, resp_start;
    logic [63:0] exp_data;
    bit          in_send, in_wait, in_ack, in_resp;

    need_b     = !op[0];
    n_send     = ((need_b && b_dly > a_dly) ? b_dly : a_dly) + 1;
    wait_len   = z_never ? (1 << 20) : z_dly + 1;
    to         = (n_send + wait_len >= T);
    z_start    = n_send + wait_len;
    resp_start = to ? T : z_start + z_hold + 1;
    exp_data   = to ? 64'd0 : (op[1] ? zd : {32'h0, zs});
    bus.output_zs = zs;
    bus.output_zd = zd;

    @(negedge clk);
    chk("idle_cmd_ready", bus.cmd_ready, 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;

    @(negedge clk);
    bus.cmd_valid = 1'($urandom);
    bus.cmd_op    = 2'($urandom);
    bus.cmd_a     = {$urandom, $urandom};
    bus.cmd_b     = {$urandom, $urandom};
    chk("setup_cmd_ready", bus.cmd_ready, 64'd0);
    chk("setup_a_stb", bus.input_a_stb, 64'd0);
    chk("setup_b_stb", bus.input_b_stb, 64'd0);
    chk("setup_process", bus.process, {62'd0, op});
    chk("setup_input_as", bus.input_as, {32'd0, a[31:0]});
    chk("setup_input_bs", bus.input_bs, {32'd0, b[31:0]});
    chk("setup_input_ad", bus.input_ad, a);
    chk("setup_input_bd", bus.input_bd, b);

    for (int t = 0; t <= resp_start + hold; t++) begin
      @(negedge clk);
      if (t == rst_at) begin
        #1 rst = 1'b1;
        #1 chk_reset_outputs("midrst");
        bus.input_a_ack  = 1'b0;
        bus.input_b_ack  = 1'b0;
        bus.output_z_stb = 1'b0;
        bus.cmd_valid    = 1'b0;
        bus.rsp_ready    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        $display("txn %0d op=%0d reset asserted at cycle %0d of SEND/WAIT_Z", txn, op, t);
        txn++;
        return;
      end
      in_send = (t < n_send) && (t < resp_start);
      in_wait = !in_send && (t < z_start) && (t < resp_start);
      in_ack  = (t >= z_start) && (t < resp_start);
      in_resp = (t >= resp_start);

      chk("a_stb", bus.input_a_stb, {63'd0, in_send && (t <= a_dly)});
      chk("b_stb", bus.input_b_stb, {63'd0, in_send && need_b && (t <= b_dly)});
      chk("z_ack", bus.output_z_ack, {63'd0, in_ack});
      chk("rsp_valid", bus.rsp_valid, {63'd0, in_resp});
      chk("busy_cmd_ready", bus.cmd_ready, 64'd0);
      chk("stable_input_ad", bus.input_ad, a);
      if (in_resp) begin
        chk("rsp_data", bus.rsp_data, exp_data);
        chk("rsp_op", bus.rsp_op, {62'd0, op});
        chk("rsp_timeout", bus.rsp_timeout, {63'd0, to});
      end

      bus.input_a_ack  = in_send && (t == a_dly);
      bus.input_b_ack  = in_send && need_b && (t == b_dly);
      if (in_send)      bus.output_z_stb = 1'($urandom);
      else if (in_wait) bus.output_z_stb = !z_never && (t == n_send + z_dly);
      else if (in_ack)  bus.output_z_stb = (t - z_start) < z_hold;
      else              bus.output_z_stb = 1'b0;
      if (in_resp) begin
        bus.rsp_ready = (t == resp_start + hold);
        bus.cmd_valid = (t < resp_start + hold) ? 1'($urandom) : 1'b0;
      end else begin
        bus.rsp_ready = 1'($urandom);
        bus.cmd_valid = 1'($urandom);
      end
    end

    @(negedge clk);
    chk("after_rsp_valid", bus.rsp_valid, 64'd0);
    chk("after_cmd_ready", bus.cmd_ready, 64'd1);
    bus.rsp_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    $display("txn %0d op=%0d a=%h b=%h exp_data=%h timeout=%0b rsp_data=%h",
             txn, op, a, b, exp_data, to, bus.rsp_data);
    txn++;
  endtask

  initial begin
    bus.cmd_valid    = 1'b0;
    bus.cmd_op       = 2'd0;
    bus.cmd_a        = '0;
    bus.cmd_b        = '0;
    bus.input_a_ack  = 1'b0;
    bus.input_b_ack  = 1'b0;
    bus.output_zs    = '0;
    bus.output_zd    = '0;
    bus.output_z_stb = 1'b0;
    bus.rsp_ready    = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst = 1'b0;

    // Single divide pi/2.0, acks after 2 cycles, z after 10.
    do_op(2'b00, 64'h0000_0000_4049_0FDB, 64'h0000_0000_4000_0000,
          32'h3FC9_0FDB, 64'hDEAD_BEEF_0123_4567, 2, 2, 7, 0, 0, 1'b0, -1);
    // Double sqrt of 4.0: b strobe must stay low.
    do_op(2'b11, 64'h4010_0000_0000_0000, 64'h1234_5678_9ABC_DEF0,
          32'h5555_AAAA, 64'h4000_0000_0000_0000, 0, 0, 0, 0, 0, 1'b0, -1);
    // Skewed acks: b three cycles before a.
    do_op(2'b10, 64'h4008_0000_0000_0000, 64'h4000_0000_0000_0000,
          32'h0, 64'h3FF8_0000_0000_0000, 3, 0, 1, 1, 0, 1'b0, -1);
    // Simultaneous a/b acks.
    do_op(2'b00, 64'h0000_0000_4100_0000, 64'h0000_0000_4000_0000,
          32'h4080_0000, 64'h0, 1, 1, 0, 0, 0, 1'b0, -1);
    // Timeout waiting for z.
    do_op(2'b00, 64'h0000_0000_3F80_0000, 64'h0000_0000_3F80_0000,
          32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, 0, 0, 1'b1, -1);
    // Timeout in SEND: a never acked.
    do_op(2'b10, 64'h1, 64'h2, 32'h3, 64'h4, 100, 1, 0, 0, 2, 1'b1, -1);
    // Response backpressure for 8 cycles.
    do_op(2'b01, 64'h0000_0000_4080_0000, 64'h0,
          32'h4000_0000, 64'hCAFE_F00D_CAFE_F00D, 0, 0, 2, 0, 8, 1'b0, -1);
    // Reset while in WAIT_Z, then a normal operation.
    do_op(2'b01, 64'h0000_0000_4110_0000, 64'h0,
          32'h4040_0000, 64'h0, 0, 0, 0, 0, 0, 1'b1, 3);
    do_op(2'b01, 64'h0000_0000_4110_0000, 64'h0,
          32'h4040_0000, 64'h0, 0, 0, 0, 0, 0, 1'b0, -1);

    for (int i = 0; i < 30; i++) begin
      do_op(2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
            $urandom, {$urandom, $urandom},
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
            int'($urandom_range(0, 3)), 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
